intra_plane_param_calc: RTL and testbench

- Computes the H.264 plane-prediction parameters (b, c, top-left seed) for one block per start request.
- Parameterised successor to the fixed 8-bit plane precalc: own sequencer, selectable bit depth, luma 16x16 / chroma 8x8 / chroma 8x16 (4:2:2), valid/ready result handshake, and a registered per-4x4 seed query port.
- Sits between the neighbour-sample buffers and the intra-prediction PE array.

---
 rtl/intra_plane_param_calc.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_intra_plane_param_calc.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_plane_param_calc.sv
// -----------------------------------------------------------------------------
// intra_plane_param_calc
//
// Computes the H.264 intra plane-prediction parameters for one block per start
// request: horizontal gradient b, vertical gradient c and the top-left seed
// such that pred(x,y) = Clip((seed + x*b + y*c) >>> 5).
//
// Supported geometries: luma 16x16 (mode 0), chroma 8x8 (mode 1) and, when
// the INTRA_PLANE_422_EN macro is defined, chroma 8x16 (mode 2). Mode 3 (and
// mode 2 in the default build) is rejected with a one-cycle err pulse.
//
// Sequencer: IDLE -> ACCUM (one weighted difference per cycle, k = N..1)
//            -> SCALE (b, c) -> SEED (seed) -> HOLD (valid/ready handshake).
// The neighbour inputs are not captured; they must stay stable from the
// accepted start until ACCUM is left.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, mode       request pulse (accepted in IDLE only) and block geometry
//   up_row, left_col  16 packed neighbour samples each, p[i,-1] / p[-1,i]
//   up_left           corner sample p[-1,-1]
//   busy              high while ACCUM/SCALE/SEED
//   err               one-cycle pulse on a rejected start
//   out_valid         b/c/seed valid (HOLD); out_ready completes the handshake
//   b, c, seed        signed results, stable while out_valid
//   blk_req/x/y       per-4x4 seed query, honoured only while out_valid
//   blk_seed(_valid)  seed + 4*blk_x*b + 4*blk_y*c, one cycle after blk_req
// -----------------------------------------------------------------------------
module intra_plane_param_calc #(
  parameter  int BIT_DEPTH = 8,
  localparam int WHV       = BIT_DEPTH + 7,
  localparam int WB        = BIT_DEPTH + 4,
  localparam int WS        = BIT_DEPTH + 8,
  localparam int WQ        = BIT_DEPTH + 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [16*BIT_DEPTH-1:0]     up_row,
  input  logic [16*BIT_DEPTH-1:0]     left_col,
  input  logic [BIT_DEPTH-1:0]        up_left,
  output logic                        busy,
  output logic                        err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WB-1:0]        b,
  output logic signed [WB-1:0]        c,
  output logic signed [WS-1:0]        seed,
  input  logic                        blk_req,
  input  logic [1:0]                  blk_x,
  input  logic [1:0]                  blk_y,
  output logic signed [WQ-1:0]        blk_seed,
  output logic                        blk_seed_valid
);

  // Internal widths with headroom so no intermediate can wrap before the
  // final truncation to the output widths.
  localparam int WP  = WHV + 8;
  localparam int WSE = WS + 4;
  localparam int WQE = WQ + 4;

  localparam logic [1:0] MODE_LUMA16  = 2'd0;
  localparam logic [1:0] MODE_CHROMA8 = 2'd1;
`ifdef INTRA_PLANE_422_EN
  localparam logic [1:0] MODE_CHROMA816 = 2'd2;
`endif

  localparam logic signed [WP-1:0]  K5       = WP'(5);
  localparam logic signed [WP-1:0]  K34      = WP'(34);
  localparam logic signed [WP-1:0]  SCALE_RND = WP'(32);
  localparam logic signed [WSE-1:0] SEED_RND = WSE'(16);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_SCALE,
    S_SEED,
    S_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [3:0]             k_q, k_d;
  logic signed [WHV-1:0]  hs_q, hs_d;
  logic signed [WHV-1:0]  vs_q, vs_d;
  logic signed [WB-1:0]   b_q, b_d;
  logic signed [WB-1:0]   c_q, c_d;
  logic signed [WS-1:0]   seed_q, seed_d;
  logic                   err_q, err_d;
  logic signed [WQ-1:0]   blk_seed_q, blk_seed_d;
  logic                   blk_seed_valid_q, blk_seed_valid_d;

  // ---------------------------------------------------------------------------
  // Neighbour unpacking
  // ---------------------------------------------------------------------------
  logic [BIT_DEPTH-1:0] up_s   [16];
  logic [BIT_DEPTH-1:0] left_s [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      up_s[i]   = up_row[i*BIT_DEPTH +: BIT_DEPTH];
      left_s[i] = left_col[i*BIT_DEPTH +: BIT_DEPTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Start decode: legality and initial k (= max(NH, NV)) from the live mode
  // ---------------------------------------------------------------------------
  logic       start_legal;
  logic [3:0] start_n;

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    start_legal = 1'b0;
    start_n     = 4'd4;
    case (mode)
      MODE_LUMA16: begin
        start_legal = 1'b1;
        start_n     = 4'd8;
      end
      MODE_CHROMA8: begin
        start_legal = 1'b1;
        start_n     = 4'd4;
      end
`ifdef INTRA_PLANE_422_EN
      MODE_CHROMA816: begin
        start_legal = 1'b1;
        start_n     = 4'd8;
      end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Geometry of the latched mode: term counts, half-size minus one, size minus one
  // ---------------------------------------------------------------------------
  logic [3:0] nh, nv, hw_m1, hh_m1, w_m1, h_m1;

  always_comb begin
    nh    = 4'd4;
    nv    = 4'd4;
    hw_m1 = 4'd3;
    hh_m1 = 4'd3;
    w_m1  = 4'd7;
    h_m1  = 4'd7;
    if (mode_q == MODE_LUMA16) begin
      nh    = 4'd8;
      nv    = 4'd8;
      hw_m1 = 4'd7;
      hh_m1 = 4'd7;
      w_m1  = 4'd15;
      h_m1  = 4'd15;
    end
`ifdef INTRA_PLANE_422_EN
    else if (mode_q == MODE_CHROMA816) begin
      nv    = 4'd8;
      hh_m1 = 4'd7;
      h_m1  = 4'd15;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // ACCUM datapath: k-weighted difference of the mirrored sample pair
  // ---------------------------------------------------------------------------
  logic [3:0]             h_hi_idx, h_lo_idx, v_hi_idx, v_lo_idx;
  logic [BIT_DEPTH-1:0]   h_hi, h_lo, v_hi, v_lo;
  logic signed [BIT_DEPTH:0] h_diff, v_diff;
  logic signed [4:0]      k_s;
  logic signed [WHV-1:0]  h_term, v_term;

  always_comb begin
    h_hi_idx = hw_m1 + k_q;
    h_lo_idx = hw_m1 - k_q;
    v_hi_idx = hh_m1 + k_q;
    v_lo_idx = hh_m1 - k_q;
    h_hi     = up_s[h_hi_idx];
    v_hi     = left_s[v_hi_idx];
    // The outermost term reaches index -1, which is the corner sample.
    h_lo     = (k_q > hw_m1) ? up_left : up_s[h_lo_idx];
    v_lo     = (k_q > hh_m1) ? up_left : left_s[v_lo_idx];
    h_diff   = $signed({1'b0, h_hi}) - $signed({1'b0, h_lo});
    v_diff   = $signed({1'b0, v_hi}) - $signed({1'b0, v_lo});
    k_s      = $signed({1'b0, k_q});
    h_term   = WHV'(h_diff) * WHV'(k_s);
    v_term   = WHV'(v_diff) * WHV'(k_s);
  end

  // ---------------------------------------------------------------------------
  // SCALE datapath: rounded, floor-shifted gradients
  // ---------------------------------------------------------------------------
  logic signed [WP-1:0] hs_w, vs_w, b_full, c_full;

  always_comb begin
    hs_w   = WP'(hs_q);
    vs_w   = WP'(vs_q);
    b_full = (hs_w * ((mode_q == MODE_LUMA16)  ? K5  : K34) + SCALE_RND) >>> 6;
    c_full = (vs_w * ((mode_q == MODE_CHROMA8) ? K34 : K5)  + SCALE_RND) >>> 6;
  end

  // ---------------------------------------------------------------------------
  // SEED datapath: seed = 16*(far top + far left) - (W/2-1)*b - (H/2-1)*c + 16
  // ---------------------------------------------------------------------------
  logic signed [WSE-1:0] far_sum, b_se, c_se, hw_se, hh_se, seed_full;

  always_comb begin
    far_sum   = $signed(WSE'(up_s[w_m1])) + $signed(WSE'(left_s[h_m1]));
    b_se      = WSE'(b_q);
    c_se      = WSE'(c_q);
    hw_se     = $signed(WSE'(hw_m1));
    hh_se     = $signed(WSE'(hh_m1));
    seed_full = (far_sum <<< 4) - hw_se * b_se - hh_se * c_se + SEED_RND;
  end

  // ---------------------------------------------------------------------------
  // Query datapath: seed of the top-left pixel of 4x4 block (blk_x, blk_y)
  // ---------------------------------------------------------------------------
  logic signed [WQE-1:0] seed_qe, b_qe, c_qe, bx_qe, by_qe, blk_full;

  always_comb begin
    seed_qe  = WQE'(seed_q);
    b_qe     = WQE'(b_q);
    c_qe     = WQE'(c_q);
    bx_qe    = $signed(WQE'({blk_x, 2'b00}));
    by_qe    = $signed(WQE'({blk_y, 2'b00}));
    blk_full = seed_qe + bx_qe * b_qe + by_qe * c_qe;
  end

  // High bits dropped by the final truncations; legal inputs never use them.
  logic unused_high_bits;
  assign unused_high_bits = ^{b_full[WP-1:WB], c_full[WP-1:WB],
                              seed_full[WSE-1:WS], blk_full[WQE-1:WQ]};

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    k_d     = k_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    b_d     = b_q;
    c_d     = c_q;
    seed_d  = seed_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_legal) begin
            mode_d  = mode;
            k_d     = start_n;
            hs_d    = '0;
            vs_d    = '0;
            state_d = S_ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        // k runs over max(NH, NV); the shorter direction skips its upper terms.
        if (k_q <= nh) hs_d = hs_q + h_term;
        if (k_q <= nv) vs_d = vs_q + v_term;
        k_d = k_q - 4'd1;
        if (k_q == 4'd1) state_d = S_SCALE;
      end
      S_SCALE: begin
        b_d     = b_full[WB-1:0];
        c_d     = c_full[WB-1:0];
        state_d = S_SEED;
      end
      S_SEED: begin
        seed_d  = seed_full[WS-1:0];
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // start is deliberately not looked at here.
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    blk_seed_valid_d = blk_req && (state_q == S_HOLD);
    blk_seed_d       = blk_seed_valid_d ? blk_full[WQ-1:0] : blk_seed_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      mode_q           <= MODE_LUMA16;
      k_q              <= '0;
      hs_q             <= '0;
      vs_q             <= '0;
      b_q              <= '0;
      c_q              <= '0;
      seed_q           <= '0;
      err_q            <= 1'b0;
      blk_seed_q       <= '0;
      blk_seed_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      k_q              <= k_d;
      hs_q             <= hs_d;
      vs_q             <= vs_d;
      b_q              <= b_d;
      c_q              <= c_d;
      seed_q           <= seed_d;
      err_q            <= err_d;
      blk_seed_q       <= blk_seed_d;
      blk_seed_valid_q <= blk_seed_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy           = (state_q == S_ACCUM) || (state_q == S_SCALE) ||
                          (state_q == S_SEED);
  assign out_valid      = (state_q == S_HOLD);
  assign err            = err_q;
  assign b              = b_q;
  assign c              = c_q;
  assign seed           = seed_q;
  assign blk_seed       = blk_seed_q;
  assign blk_seed_valid = blk_seed_valid_q;

endmodule

// File: tb/tb_intra_plane_param_calc.sv
// -----------------------------------------------------------------------------
// Self-checking bench for intra_plane_param_calc (BIT_DEPTH = 8).
// Expected results are pushed to a scoreboard when a request is launched and
// compared when out_valid rises; query results use a second scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_intra_plane_param_calc;

  localparam int BD = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [1:0]               mode;
  logic [16*BD-1:0]         up_row;
  logic [16*BD-1:0]         left_col;
  logic [BD-1:0]            up_left;
  logic                     busy;
  logic                     err;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [BD+3:0]     b;
  logic signed [BD+3:0]     c;
  logic signed [BD+7:0]     seed;
  logic                     blk_req;
  logic [1:0]               blk_x;
  logic [1:0]               blk_y;
  logic signed [BD+8:0]     blk_seed;
  logic                     blk_seed_valid;

  intra_plane_param_calc #(.BIT_DEPTH(BD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode           (mode),
    .up_row         (up_row),
    .left_col       (left_col),
    .up_left        (up_left),
    .busy           (busy),
    .err            (err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .b              (b),
    .c              (c),
    .seed           (seed),
    .blk_req        (blk_req),
    .blk_x          (blk_x),
    .blk_y          (blk_y),
    .blk_seed       (blk_seed),
    .blk_seed_valid (blk_seed_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b;
    int c;
    int seed;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   qexp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   up_arr[16];
  int   left_arr[16];
  int   ul;
  int   last_blk = 0;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic int up_at(input int idx);
    return (idx < 0) ? ul : up_arr[idx];
  endfunction

  function automatic int left_at(input int idx);
    return (idx < 0) ? ul : left_arr[idx];
  endfunction

  function automatic exp_t model(input int m);
    exp_t e;
    int nh, nv, w, h, hs, vs;
    if (m == 0) begin
      nh = 8; nv = 8; w = 16; h = 16;
    end else if (m == 1) begin
      nh = 4; nv = 4; w = 8; h = 8;
    end else begin
      nh = 4; nv = 8; w = 8; h = 16;
    end
    hs = 0;
    vs = 0;
    for (int k = 1; k <= nh; k++) hs += k * (up_at(w/2-1+k) - up_at(w/2-1-k));
    for (int k = 1; k <= nv; k++) vs += k * (left_at(h/2-1+k) - left_at(h/2-1-k));
    e.b    = (m == 0) ? ((5*hs + 32) >>> 6) : ((34*hs + 32) >>> 6);
    e.c    = (m == 1) ? ((34*vs + 32) >>> 6) : ((5*vs + 32) >>> 6);
    e.seed = 16*(up_at(w-1) + left_at(h-1)) - (w/2-1)*e.b - (h/2-1)*e.c + 16;
    e.lat  = (m == 1) ? 6 : 10;
    return e;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic apply_samples();
    for (int i = 0; i < 16; i++) begin
      up_row[i*BD +: BD]   = up_arr[i][BD-1:0];
      left_col[i*BD +: BD] = left_arr[i][BD-1:0];
    end
    up_left = ul[BD-1:0];
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      up_arr[i]   = $urandom_range(0, 255);
      left_arr[i] = $urandom_range(0, 255);
    end
    ul = $urandom_range(0, 255);
  endtask

  // Drive a start at the current falling edge; returns after edge E0.
  task automatic launch(input logic [1:0] m);
    apply_samples();
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for out_valid (bounded), then checks latency and results.
  task automatic wait_result(input string name);
    exp_t e;
    int   lat = 0;
    int   ab, ac, as;
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL %s err_on_legal: got %b expected 0", name, err);
    end
    while (out_valid !== 1'b1 && lat < 40) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_errors++;
        $display("FAIL %s busy_during_op: got %b expected 1 at cycle %0d", name, busy, lat);
      end
      @(negedge clk);
      lat++;
    end
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s scoreboard_empty: got 0 entries expected 1", name);
      return;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (lat != e.lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    end
    ab = b; ac = c; as = seed;
    n_checks++;
    if (ab !== e.b) begin
      n_errors++;
      $display("FAIL %s b: got %0d expected %0d", name, ab, e.b);
    end
    n_checks++;
    if (ac !== e.c) begin
      n_errors++;
      $display("FAIL %s c: got %0d expected %0d", name, ac, e.c);
    end
    n_checks++;
    if (as !== e.seed) begin
      n_errors++;
      $display("FAIL %s seed: got %0d expected %0d", name, as, e.seed);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy_in_hold: got %b expected 0", name, busy);
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s valid_after_ready: got %b expected 0", name, out_valid);
    end
  endtask

  // Back-to-back queries, first at (fx, fy), the rest random.
  task automatic query_burst(input exp_t e, input int fx, input int fy, input int n);
    int x, y, expv, act;
    for (int i = 0; i < n; i++) begin
      x = (i == 0) ? fx : int'($urandom_range(0, 3));
      y = (i == 0) ? fy : int'($urandom_range(0, 3));
      blk_req = 1'b1;
      blk_x   = x[1:0];
      blk_y   = y[1:0];
      qexp_q.push_back(e.seed + 4*x*e.b + 4*y*e.c);
      @(negedge clk);
      n_checks++;
      if (blk_seed_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL query_valid: got %b expected 1 (x=%0d y=%0d)", blk_seed_valid, x, y);
      end
      expv = qexp_q.pop_front();
      act  = blk_seed;
      n_checks++;
      if (act !== expv) begin
        n_errors++;
        $display("FAIL query_value: got %0d expected %0d (x=%0d y=%0d)", act, expv, x, y);
      end
      last_blk = expv;
    end
    blk_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (blk_seed_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL query_valid_drop: got %b expected 0", blk_seed_valid);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, err, out_valid, blk_seed_valid} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, err, out_valid, blk_seed_valid});
    end
    n_checks++;
    if ({b, c, seed, blk_seed} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got b=%0d c=%0d seed=%0d blk=%0d expected all 0", b, c, seed, blk_seed);
    end
    rst_n = 1'b1;
    last_blk = 0;
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_idle: got busy/valid %b expected 00", {busy, out_valid});
    end
  endtask

  task automatic set_flat();
    for (int i = 0; i < 16; i++) begin
      up_arr[i]   = 128;
      left_arr[i] = 128;
    end
    ul = 128;
  endtask

  task automatic test_flat_luma();
    exp_t e;
    set_flat();
    e.b = 0; e.c = 0; e.seed = 4112; e.lat = 10;
    sb_q.push_back(e);
    launch(2'd0);
    wait_result("flat_luma");
    handshake("flat_luma");
  endtask

  task automatic test_luma_ramp();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      up_arr[i]   = 16 + 4*i;
      left_arr[i] = 12;
    end
    ul = 12;
    e.b = 128; e.c = 0; e.seed = 528; e.lat = 10;
    sb_q.push_back(e);
    launch(2'd0);
    wait_result("luma_ramp");
    query_burst(e, 1, 0, 5);
    handshake("luma_ramp");
  endtask

  task automatic test_chroma_neg();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      up_arr[i]   = 208;
      left_arr[i] = (i < 8) ? 200 - 8*i : 0;
    end
    ul = 208;
    e.b = 0; e.c = -255; e.seed = 6413; e.lat = 6;
    sb_q.push_back(e);
    launch(2'd1);
    wait_result("chroma_neg");
    query_burst(e, 3, 3, 2);
    handshake("chroma_neg");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   ab, ac, as;
    fill_random();
    e = model(0);
    sb_q.push_back(e);
    launch(2'd0);
    wait_result("backpressure");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        mode  = 2'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      ab = b; ac = c; as = seed;
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_flags: got valid=%b busy=%b expected 1/0 (cycle %0d)", out_valid, busy, i);
      end
      n_checks++;
      if (ab !== e.b || ac !== e.c || as !== e.seed) begin
        n_errors++;
        $display("FAIL hold_stable: got %0d/%0d/%0d expected %0d/%0d/%0d", ab, ac, as, e.b, e.c, e.seed);
      end
    end
    // start together with out_ready is also ignored
    start     = 1'b1;
    mode      = 2'd0;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_with_start: got valid=%b busy=%b expected 0/0", out_valid, busy);
    end
    // earliest back-to-back start
    fill_random();
    e = model(1);
    sb_q.push_back(e);
    launch(2'd1);
    wait_result("back_to_back");
    handshake("back_to_back");
  endtask

  task automatic illegal_start(input logic [1:0] m, input string name);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s err_pulse: got err=%b busy=%b expected 1/0", name, err, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({err, busy, out_valid} !== 3'b000) begin
        n_errors++;
        $display("FAIL %s after_err: got err/busy/valid %b expected 000", name, {err, busy, out_valid});
      end
    end
  endtask

  task automatic test_illegal_mode();
    illegal_start(2'd3, "mode3");
`ifdef INTRA_PLANE_422_EN
    begin
      exp_t e;
      fill_random();
      e = model(2);
      sb_q.push_back(e);
      launch(2'd2);
      wait_result("chroma_422");
      query_burst(e, 2, 3, 3);
      handshake("chroma_422");
    end
`else
    illegal_start(2'd2, "mode2_disabled");
`endif
  endtask

  task automatic test_reset_mid_accum();
    exp_t e;
    int   act;
    for (int i = 0; i < 16; i++) begin
      up_arr[i]   = 16 + 4*i;
      left_arr[i] = 240 - 10*i;
    end
    ul = 12;
    launch(2'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, err, out_valid, blk_seed_valid} !== 4'b0000) begin
      n_errors++;
      $display("FAIL midreset_flags: got %b expected 0000", {busy, err, out_valid, blk_seed_valid});
    end
    n_checks++;
    if ({b, c, seed, blk_seed} !== '0) begin
      n_errors++;
      $display("FAIL midreset_data: got b=%0d c=%0d seed=%0d blk=%0d expected all 0", b, c, seed, blk_seed);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    last_blk = 0;
    @(negedge clk);
    // query outside HOLD is dropped
    blk_req = 1'b1;
    blk_x   = 2'd1;
    blk_y   = 2'd1;
    @(negedge clk);
    blk_req = 1'b0;
    act     = blk_seed;
    n_checks++;
    if (blk_seed_valid !== 1'b0 || act !== last_blk) begin
      n_errors++;
      $display("FAIL idle_query: got valid=%b value=%0d expected 0/%0d", blk_seed_valid, act, last_blk);
    end
    set_flat();
    e.b = 0; e.c = 0; e.seed = 4112; e.lat = 10;
    sb_q.push_back(e);
    launch(2'd0);
    wait_result("after_reset");
    handshake("after_reset");
  endtask

  task automatic test_random();
    exp_t e;
    int   m;
    for (int it = 0; it < 8; it++) begin
`ifdef INTRA_PLANE_422_EN
      m = $urandom_range(0, 2);
`else
      m = $urandom_range(0, 1);
`endif
      fill_random();
      e = model(m);
      sb_q.push_back(e);
      launch(m[1:0]);
      wait_result("random");
      query_burst(e, 0, 0, 3);
      handshake("random");
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    out_ready = 1'b0;
    blk_req   = 1'b0;
    blk_x     = 2'd0;
    blk_y     = 2'd0;
    up_row    = '0;
    left_col  = '0;
    up_left   = '0;
    @(negedge clk);
    test_reset();
    test_flat_luma();
    test_luma_ramp();
    test_chroma_neg();
    test_backpressure();
    test_illegal_mode();
    test_reset_mid_accum();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
